// File: rtl/jesd207_ensm_responder_if.sv
// jesd207_ensm_responder_if: JESD207 control pair, local RX source and TX deframe bus.
// Revision 1.0 - initial release
`default_nettype none

interface jesd207_ensm_responder_if #(
  parameter int DW = 12
);
  logic          enable;
  logic          txnrx;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] rx_data;
  logic          rx_frame;
  logic [DW-1:0] tx_data;
  logic          tx_frame;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_first;
  logic [2:0]    state;
  logic          underrun;
  logic          frame_err;

  modport master (
    output enable, txnrx, s_data, s_valid, tx_data, tx_frame,
    input  s_ready, rx_data, rx_frame, m_data, m_valid, m_first, state, underrun, frame_err
  );

  modport slave (
    input  enable, txnrx, s_data, s_valid, tx_data, tx_frame,
    output s_ready, rx_data, rx_frame, m_data, m_valid, m_first, state, underrun, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/jesd207_ensm_responder.sv
// jesd207_ensm_responder: RF-side ENSM, framed RX source and TX deframer.
// Optional macro JESD207_PULSE_MODE_EN selects pulse-mode enable. Revision 1.0
`default_nettype none

module jesd207_ensm_responder #(
  parameter int DW        = 12,
  parameter int FRAME_LEN = 2,
  parameter int EN_DELAY  = 4
) (
  input wire logic                 mclk,
  input wire logic                 rstn,
  jesd207_ensm_responder_if.slave  bus
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [3:0] c_DELAY_LOAD = 4'(EN_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_WAIT  = 3'd1,
    S_RX       = 3'd2,
    S_RX_DRAIN = 3'd3,
    S_TX_WAIT  = 3'd4,
    S_TX       = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_en;
  logic [3:0]      r_cnt;
  logic            w_cnt_load;
  logic [IW-1:0]   r_idx, w_idx_inc;
  logic [DW-1:0]   r_rx_data;
  logic            r_rx_frame, r_underrun;
  logic [DW-1:0]   r_txd, r_m_data;
  logic            r_txf, r_tx_v;
  logic            r_aligned;
  logic [IW-1:0]   r_tidx, w_tidx_inc;
  logic            r_m_valid, r_m_first, r_frame_err;
  logic            w_rise, w_fall, w_start, w_stop;
  logic            w_rx_slot, w_tx_go;

  assign w_rise = bus.enable & ~r_en;
  assign w_fall = ~bus.enable & r_en;

`ifdef JESD207_PULSE_MODE_EN
  // Each rising edge toggles the burst; the enable level carries no meaning.
  assign w_start = w_rise;
  assign w_stop  = w_rise;
`else
  assign w_start = w_rise;
  assign w_stop  = w_fall;
`endif

  assign w_idx_inc  = r_idx + IW'(1);
  assign w_tidx_inc = r_tidx + IW'(1);
  assign w_rx_slot  = (r_state == S_RX) || (r_state == S_RX_DRAIN);
  assign w_tx_go    = r_tx_v && (r_state == S_TX) && (w_state_nxt == S_TX);

  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_en    <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= bus.enable;
      if (w_cnt_load)
        r_cnt <= c_DELAY_LOAD;
      else if (((r_state == S_RX_WAIT) || (r_state == S_TX_WAIT)) && (r_cnt != 4'd0))
        r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = bus.txnrx ? S_TX_WAIT : S_RX_WAIT;
          w_cnt_load  = 1'b1;
        end
      end
      S_RX_WAIT: begin
        if (w_stop)              w_state_nxt = S_IDLE;
        else if (r_cnt == 4'd0)  w_state_nxt = S_RX;
      end
      S_TX_WAIT: begin
        if (w_stop)              w_state_nxt = S_IDLE;
        else if (r_cnt == 4'd0)  w_state_nxt = S_TX;
      end
      // The slot served this cycle still counts; drain only if the frame is unfinished.
      S_RX: begin
        if (w_stop) w_state_nxt = (w_idx_inc == '0) ? S_IDLE : S_RX_DRAIN;
      end
      S_RX_DRAIN: begin
        if (w_idx_inc == '0) w_state_nxt = S_IDLE;
      end
      S_TX: begin
        if (w_stop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      r_rx_data  <= '0;
      r_rx_frame <= 1'b0;
      r_idx      <= '0;
      r_underrun <= 1'b0;
    end else if (w_rx_slot) begin
      r_rx_data  <= bus.s_valid ? bus.s_data : '0;
      r_rx_frame <= (r_idx == '0);
      r_idx      <= w_idx_inc;
      if (!bus.s_valid) r_underrun <= 1'b1;
    end else begin
      r_rx_data  <= '0;
      r_rx_frame <= 1'b0;
      r_idx      <= '0;
    end
  end

  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      r_txd       <= '0;
      r_txf       <= 1'b0;
      r_tx_v      <= 1'b0;
      r_aligned   <= 1'b0;
      r_tidx      <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_first   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_txd       <= bus.tx_data;
      r_txf       <= bus.tx_frame;
      r_tx_v      <= (r_state == S_TX);
      r_m_valid   <= 1'b0;
      r_m_first   <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_state != S_TX) begin
        r_aligned <= 1'b0;
        r_tidx    <= '0;
      end else if (w_tx_go) begin
        if (r_aligned && (r_txf == (r_tidx == '0))) begin
          r_m_valid <= 1'b1;
          r_m_first <= (r_tidx == '0);
          r_m_data  <= r_txd;
          r_tidx    <= w_tidx_inc;
        end else begin
          // Marker either starts alignment or disagrees with the running index.
          r_frame_err <= r_aligned;
          if (r_txf) begin
            r_aligned <= 1'b1;
            r_m_valid <= 1'b1;
            r_m_first <= 1'b1;
            r_m_data  <= r_txd;
            r_tidx    <= IW'(1);
          end else begin
            r_aligned <= 1'b0;
            r_tidx    <= '0;
          end
        end
      end
    end
  end

  assign bus.state     = r_state;
  assign bus.s_ready   = w_rx_slot;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_frame  = r_rx_frame;
  assign bus.underrun  = r_underrun;
  assign bus.m_data    = r_m_data;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_first   = r_m_first;
  assign bus.frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_jesd207_ensm_responder.sv
// tb_jesd207_ensm_responder: directed checks of ENSM, RX framing and TX deframing.
// Revision 1.0
`default_nettype none

module tb_jesd207_ensm_responder;

  logic mclk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  jesd207_ensm_responder_if #(.DW(12)) bus();

  jesd207_ensm_responder #(.DW(12), .FRAME_LEN(2), .EN_DELAY(4)) dut (
    .mclk (mclk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    logic take;
    take = bus.s_ready && bus.s_valid;
    @(posedge mclk);
    #1;
    if (take) bus.s_data = bus.s_data + 12'd1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    n_checks++; if (bus.s_ready !== 1'b0) begin n_errors++; $display("FAIL reset_s_ready: got %b expected 0", bus.s_ready); end
    n_checks++; if (bus.rx_data !== 12'h000) begin n_errors++; $display("FAIL reset_rx_data: got %h expected 000", bus.rx_data); end
    n_checks++; if (bus.rx_frame !== 1'b0) begin n_errors++; $display("FAIL reset_rx_frame: got %b expected 0", bus.rx_frame); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
    n_checks++; if (bus.m_first !== 1'b0) begin n_errors++; $display("FAIL reset_m_first: got %b expected 0", bus.m_first); end
    n_checks++; if (bus.m_data !== 12'h000) begin n_errors++; $display("FAIL reset_m_data: got %h expected 000", bus.m_data); end
    n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL reset_underrun: got %b expected 0", bus.underrun); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    rstn = 1'b1;
    tick();
    n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL post_reset_state: got %0d expected 0", bus.state); end
  endtask

  task automatic test_rx_basic();
    bus.s_data = 12'h001; bus.s_valid = 1'b1; bus.txnrx = 1'b0; bus.enable = 1'b1;
    tick();
    n_checks++; if (bus.state !== 3'd1) begin n_errors++; $display("FAIL rx_wait_state: got %0d expected 1", bus.state); end
    n_checks++; if (bus.s_ready !== 1'b0) begin n_errors++; $display("FAIL rx_wait_s_ready: got %b expected 0", bus.s_ready); end
    repeat (3) tick();
    n_checks++; if (bus.state !== 3'd1) begin n_errors++; $display("FAIL rx_wait_hold: got %0d expected 1", bus.state); end
    tick();
    n_checks++; if (bus.state !== 3'd2) begin n_errors++; $display("FAIL rx_enter: got %0d expected 2", bus.state); end
    n_checks++; if (bus.s_ready !== 1'b1) begin n_errors++; $display("FAIL rx_s_ready: got %b expected 1", bus.s_ready); end
    n_checks++; if (bus.rx_data !== 12'h000) begin n_errors++; $display("FAIL rx_pre_data: got %h expected 000", bus.rx_data); end
    tick();
    n_checks++; if ({bus.rx_data, bus.rx_frame} !== {12'h001, 1'b1}) begin n_errors++; $display("FAIL rx_s0: got %h/%b expected 001/1", bus.rx_data, bus.rx_frame); end
    tick();
    n_checks++; if ({bus.rx_data, bus.rx_frame} !== {12'h002, 1'b0}) begin n_errors++; $display("FAIL rx_s1: got %h/%b expected 002/0", bus.rx_data, bus.rx_frame); end
    tick();
    n_checks++; if ({bus.rx_data, bus.rx_frame} !== {12'h003, 1'b1}) begin n_errors++; $display("FAIL rx_s2: got %h/%b expected 003/1", bus.rx_data, bus.rx_frame); end
    bus.enable = 1'b0;
    tick();
    n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL rx_exit_state: got %0d expected 0", bus.state); end
    n_checks++; if ({bus.rx_data, bus.rx_frame} !== {12'h004, 1'b0}) begin n_errors++; $display("FAIL rx_s3: got %h/%b expected 004/0", bus.rx_data, bus.rx_frame); end
    tick();
    n_checks++; if (bus.rx_data !== 12'h000) begin n_errors++; $display("FAIL rx_idle_data: got %h expected 000", bus.rx_data); end
    n_checks++; if (bus.s_ready !== 1'b0) begin n_errors++; $display("FAIL rx_idle_s_ready: got %b expected 0", bus.s_ready); end
    n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL rx_no_underrun: got %b expected 0", bus.underrun); end
  endtask

  task automatic test_rx_drain_underrun();
    bus.s_data = 12'h005; bus.s_valid = 1'b1; bus.enable = 1'b1;
    repeat (5) tick();
    n_checks++; if (bus.state !== 3'd2) begin n_errors++; $display("FAIL dr_enter: got %0d expected 2", bus.state); end
    tick();
    n_checks++; if ({bus.rx_data, bus.rx_frame} !== {12'h005, 1'b1}) begin n_errors++; $display("FAIL dr_s0: got %h/%b expected 005/1", bus.rx_data, bus.rx_frame); end
    bus.s_valid = 1'b0;
    tick();
    n_checks++; if ({bus.rx_data, bus.rx_frame} !== {12'h000, 1'b0}) begin n_errors++; $display("FAIL dr_gap: got %h/%b expected 000/0", bus.rx_data, bus.rx_frame); end
    n_checks++; if (bus.underrun !== 1'b1) begin n_errors++; $display("FAIL dr_underrun_set: got %b expected 1", bus.underrun); end
    bus.s_valid = 1'b1;
    tick();
    n_checks++; if ({bus.rx_data, bus.rx_frame} !== {12'h006, 1'b1}) begin n_errors++; $display("FAIL dr_s2: got %h/%b expected 006/1", bus.rx_data, bus.rx_frame); end
    tick();
    n_checks++; if ({bus.rx_data, bus.rx_frame} !== {12'h007, 1'b0}) begin n_errors++; $display("FAIL dr_s3: got %h/%b expected 007/0", bus.rx_data, bus.rx_frame); end
    bus.enable = 1'b0;
    tick();
    n_checks++; if (bus.state !== 3'd3) begin n_errors++; $display("FAIL dr_drain_state: got %0d expected 3", bus.state); end
    n_checks++; if (bus.s_ready !== 1'b1) begin n_errors++; $display("FAIL dr_drain_ready: got %b expected 1", bus.s_ready); end
    n_checks++; if ({bus.rx_data, bus.rx_frame} !== {12'h008, 1'b1}) begin n_errors++; $display("FAIL dr_s4: got %h/%b expected 008/1", bus.rx_data, bus.rx_frame); end
    tick();
    n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL dr_idle: got %0d expected 0", bus.state); end
    n_checks++; if ({bus.rx_data, bus.rx_frame} !== {12'h009, 1'b0}) begin n_errors++; $display("FAIL dr_s5: got %h/%b expected 009/0", bus.rx_data, bus.rx_frame); end
    tick();
    n_checks++; if (bus.underrun !== 1'b1) begin n_errors++; $display("FAIL dr_underrun_sticky: got %b expected 1", bus.underrun); end
    n_checks++; if (bus.rx_data !== 12'h000) begin n_errors++; $display("FAIL dr_idle_data: got %h expected 000", bus.rx_data); end
  endtask

  task automatic test_tx_deframe();
    logic [10:0] frames;
    logic [10:0] exp_first;
    logic [10:0] exp_err;
    frames    = 11'b01011010101;
    exp_first = 11'b01011010101;
    exp_err   = 11'b00010000000;
    bus.txnrx = 1'b1; bus.tx_data = 12'h000; bus.tx_frame = 1'b0; bus.enable = 1'b1;
    tick();
    n_checks++; if (bus.state !== 3'd4) begin n_errors++; $display("FAIL tx_wait_state: got %0d expected 4", bus.state); end
    repeat (4) tick();
    n_checks++; if (bus.state !== 3'd5) begin n_errors++; $display("FAIL tx_enter: got %0d expected 5", bus.state); end
    for (int j = 0; j < 13; j++) begin
      if (j >= 2) begin
        n_checks++; if ({bus.m_valid, bus.m_first, bus.m_data} !== {1'b1, exp_first[j-2], 12'hA00 + 12'(j-2)}) begin
          n_errors++; $display("FAIL tx_sample%0d: got v%b f%b %h expected v1 f%b %h", j-2, bus.m_valid, bus.m_first, bus.m_data, exp_first[j-2], 12'hA00 + 12'(j-2));
        end
        n_checks++; if (bus.frame_err !== exp_err[j-2]) begin n_errors++; $display("FAIL tx_frame_err%0d: got %b expected %b", j-2, bus.frame_err, exp_err[j-2]); end
      end
      if (j < 11) begin
        bus.tx_data  = 12'hA00 + 12'(j);
        bus.tx_frame = frames[j];
      end
      if (j == 12) bus.enable = 1'b0;
      tick();
    end
    n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL tx_exit_state: got %0d expected 0", bus.state); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL tx_exit_m_valid: got %b expected 0", bus.m_valid); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_errors++; $display("FAIL tx_exit_frame_err: got %b expected 0", bus.frame_err); end
    tick();
  endtask

  task automatic test_wait_abort();
    bus.txnrx = 1'b1; bus.enable = 1'b1;
    tick();
    n_checks++; if (bus.state !== 3'd4) begin n_errors++; $display("FAIL ab_wait: got %0d expected 4", bus.state); end
    bus.enable = 1'b0;
    tick();
    n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL ab_idle: got %0d expected 0", bus.state); end
    tick();
    bus.enable = 1'b1;
    repeat (4) tick();
    n_checks++; if (bus.state !== 3'd4) begin n_errors++; $display("FAIL race_wait: got %0d expected 4", bus.state); end
    bus.enable = 1'b0;
    tick();
    n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL race_fall_wins: got %0d expected 0", bus.state); end
    tick();
    n_checks++; if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL race_m_valid: got %b expected 0", bus.m_valid); end
  endtask

  task automatic test_pulse_mode();
    bus.txnrx = 1'b1; bus.tx_frame = 1'b0; bus.enable = 1'b1;
    tick();
    n_checks++; if (bus.state !== 3'd4) begin n_errors++; $display("FAIL pm_wait: got %0d expected 4", bus.state); end
    bus.enable = 1'b0;
    repeat (4) tick();
    n_checks++; if (bus.state !== 3'd5) begin n_errors++; $display("FAIL pm_tx: got %0d expected 5", bus.state); end
    repeat (14) tick();
    n_checks++; if (bus.state !== 3'd5) begin n_errors++; $display("FAIL pm_tx_hold: got %0d expected 5", bus.state); end
    bus.enable = 1'b1;
    tick();
    n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL pm_stop: got %0d expected 0", bus.state); end
    tick();
    n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL pm_level_ignored: got %0d expected 0", bus.state); end
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    tick();
    n_checks++; if (bus.state !== 3'd4) begin n_errors++; $display("FAIL pm_restart: got %0d expected 4", bus.state); end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_rx();
    rstn = 1'b1; bus.txnrx = 1'b0; bus.s_valid = 1'b1; bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    repeat (6) tick();
    n_checks++; if (bus.rx_frame !== 1'b1) begin n_errors++; $display("FAIL mr_pre_frame: got %b expected 1", bus.rx_frame); end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL mr_state: got %0d expected 0", bus.state); end
    n_checks++; if (bus.rx_frame !== 1'b0) begin n_errors++; $display("FAIL mr_rx_frame: got %b expected 0", bus.rx_frame); end
    n_checks++; if (bus.underrun !== 1'b0) begin n_errors++; $display("FAIL mr_underrun: got %b expected 0", bus.underrun); end
    n_checks++; if (bus.s_ready !== 1'b0) begin n_errors++; $display("FAIL mr_s_ready: got %b expected 0", bus.s_ready); end
    bus.enable = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL mr_after: got %0d expected 0", bus.state); end
  endtask

  initial begin
    bus.enable = 1'b0; bus.txnrx = 1'b0; bus.s_data = 12'h000; bus.s_valid = 1'b0;
    bus.tx_data = 12'h000; bus.tx_frame = 1'b0;
    test_reset();
`ifdef JESD207_PULSE_MODE_EN
    test_pulse_mode();
`else
    test_rx_basic();
    test_rx_drain_underrun();
    test_tx_deframe();
    test_wait_abort();
`endif
    test_reset_mid_rx();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
